// File: rtl/sample_generator_if.sv
// ---------------------------------------------------------------------------
// sample_generator_if
// Bundles the request, candidate/checker and solution handshake signals of
// sample_generator.
//   master : the generator side (drives cand, sol_*, busy, fail, tries)
//   slave  : the requester / checker / consumer side
//   start, seed       request strobe and optional LFSR reload value
//   cand, chk_ok      candidate to the constraint checker and its verdict
//   sol_valid/ready   solution handshake, sol_data the accepted candidate
//   busy, fail, tries status
// With SAMPLE_GENERATOR_STATS_EN defined, stat_acc / stat_rej are added.
// ---------------------------------------------------------------------------
interface sample_generator_if #(
    parameter int CAND_W = 64
);
    logic              start;
    logic [31:0]       seed;
    logic [CAND_W-1:0] cand;
    logic              chk_ok;
    logic              sol_valid;
    logic              sol_ready;
    logic [CAND_W-1:0] sol_data;
    logic              busy;
    logic              fail;
    logic [15:0]       tries;
`ifdef SAMPLE_GENERATOR_STATS_EN
    logic [31:0]       stat_acc;
    logic [31:0]       stat_rej;
`endif

    modport master (
        input  start, seed, chk_ok, sol_ready,
`ifdef SAMPLE_GENERATOR_STATS_EN
        output stat_acc, stat_rej,
`endif
        output cand, sol_valid, sol_data, busy, fail, tries
    );

    modport slave (
        output start, seed, chk_ok, sol_ready,
`ifdef SAMPLE_GENERATOR_STATS_EN
        input  stat_acc, stat_rej,
`endif
        input  cand, sol_valid, sol_data, busy, fail, tries
    );
endinterface

// File: rtl/sample_generator.sv
// ---------------------------------------------------------------------------
// sample_generator
// Rejection sampler: builds pseudo-random candidate vectors from a 32-bit
// Galois LFSR, presents each one to an external combinational constraint
// checker, and returns the first candidate the checker accepts. Gives up
// (FAIL) after MAX_TRIES rejected candidates.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   bus        sample_generator_if.master:
//                start/seed   request (accepted in IDLE or FAIL only)
//                cand/chk_ok  candidate out, checker verdict in
//                sol_valid/sol_ready/sol_data  solution handshake
//                busy/fail/tries               status
//
// Optional feature: define SAMPLE_GENERATOR_STATS_EN to add saturating
// 32-bit counters stat_acc (accepted solutions) and stat_rej (rejections).
// ---------------------------------------------------------------------------
module sample_generator #(
    parameter int          CAND_W    = 64,
    parameter int          MAX_TRIES = 1024,
    parameter logic [31:0] SEED      = 32'hACE1_0001
) (
    input  logic                clk,
    input  logic                rst,
    sample_generator_if.master  bus
);
    localparam int          NWORDS    = (CAND_W + 31) / 32;
    localparam int          REG_W     = NWORDS * 32;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [5:0]  LAST_WORD = 6'(NWORDS - 1);
    localparam logic [15:0] MAX_T     = 16'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CHECK,
        HOLD,
        FAIL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       lfsr;
    logic [REG_W-1:0]  cand_reg;
    logic [5:0]        word_cnt;
    logic [15:0]       tries_r;
    logic [15:0]       tries_inc;
    logic [CAND_W-1:0] sol_data_r;
    logic              last_fill;
    logic              rejected;
    logic              busy_c;
    logic              fail_c;
    logic              valid_c;

    // One right shift of the Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
    endfunction

    assign last_fill = (state == FILL) && (word_cnt == LAST_WORD);
    assign rejected  = (state == CHECK) && !bus.chk_ok;
    assign tries_inc = tries_r + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        fail_c    = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = FILL;
            end
            FILL: begin
                busy_c = 1'b1;
                if (last_fill) state_nxt = CHECK;
            end
            CHECK: begin
                busy_c = 1'b1;
                if (bus.chk_ok)           state_nxt = HOLD;
                else if (tries_inc == MAX_T) state_nxt = FAIL;
                else                      state_nxt = FILL;
            end
            HOLD: begin
                busy_c  = 1'b1;
                valid_c = 1'b1;
                if (bus.sol_ready) state_nxt = IDLE;
            end
            FAIL: begin
                fail_c = 1'b1;
                if (bus.start) state_nxt = FILL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= SEED;
            cand_reg   <= '0;
            word_cnt   <= '0;
            tries_r    <= '0;
            sol_data_r <= '0;
        end else begin
            case (state)
                IDLE, FAIL: begin
                    if (bus.start) begin
                        tries_r  <= '0;
                        word_cnt <= '0;
                        if (bus.seed != 32'h0) lfsr <= bus.seed;
                    end
                end
                FILL: begin
                    // Earlier words migrate toward the MSBs; the first word
                    // drawn ends up in the top of the register.
                    cand_reg <= (cand_reg << 32) | REG_W'(lfsr);
                    lfsr     <= lfsr_step(lfsr);
                    word_cnt <= last_fill ? 6'd0 : word_cnt + 6'd1;
                end
                CHECK: begin
                    if (bus.chk_ok) sol_data_r <= cand_reg[CAND_W-1:0];
                    else            tries_r    <= tries_inc;
                end
                default: ;
            endcase
        end
    end

    assign bus.cand      = cand_reg[CAND_W-1:0];
    assign bus.sol_data  = sol_data_r;
    assign bus.sol_valid = valid_c;
    assign bus.busy      = busy_c;
    assign bus.fail      = fail_c;
    assign bus.tries     = tries_r;

`ifdef SAMPLE_GENERATOR_STATS_EN
    logic [31:0] stat_acc_r;
    logic [31:0] stat_rej_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_acc_r <= '0;
            stat_rej_r <= '0;
        end else begin
            if (valid_c && bus.sol_ready) stat_acc_r <= sat_inc(stat_acc_r);
            if (rejected)                 stat_rej_r <= sat_inc(stat_rej_r);
        end
    end

    assign bus.stat_acc = stat_acc_r;
    assign bus.stat_rej = stat_rej_r;
`endif
endmodule

// File: doc/sample_generator.md
SAMPLE_GENERATOR -- requirements
Module: sample_generator

Interface
REQ-001 Parameter CAND_W, default 64: candidate vector width in bits, 1..1024.
REQ-002 Parameter MAX_TRIES, default 1024: maximum rejected candidates per request, 1..65535.
REQ-003 Parameter SEED, default 32'hACE1_0001: LFSR reset value, nonzero.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request one satisfying sample; accepted only in IDLE or FAIL.
REQ-007 seed  in  32  LFSR reload value, sampled with an accepted start; 0 means keep the current LFSR state.
REQ-008 cand  out  CAND_W  candidate assignment driven to the downstream combinational constraint checker.
REQ-009 chk_ok  in  1  checker verdict for cand (the checker's x output).
REQ-010 sol_valid  out  1  sol_data holds an accepted candidate.
REQ-011 sol_ready  in  1  consumer accepts sol_data.
REQ-012 sol_data  out  CAND_W  accepted candidate.
REQ-013 busy  out  1  high in FILL, CHECK, or HOLD.
REQ-014 fail  out  1  high in FAIL.
REQ-015 tries  out  16  rejected-candidate count for the current request.

Function
REQ-016 NWORDS SHALL equal ceil(CAND_W/32); LFSR SHALL be 32-bit Galois, taps mask 32'h8020_0003, shifted right one step per FILL cycle.
REQ-017 States SHALL be IDLE, FILL, CHECK, HOLD, FAIL; reset state SHALL be IDLE.
REQ-018 IDLE/FAIL + start SHALL go to FILL, clear tries and the word counter, and load the LFSR with seed if seed != 0.
REQ-019 Each FILL cycle SHALL shift the candidate register left 32 and insert the current LFSR word in the low bits, then advance the LFSR; after NWORDS FILL cycles the state SHALL become CHECK.
REQ-020 cand SHALL be the low CAND_W bits of the candidate register and SHALL be stable throughout CHECK.
REQ-021 CHECK with chk_ok=1 SHALL go to HOLD and copy cand to sol_data.
REQ-022 CHECK with chk_ok=0 SHALL increment tries, go to FAIL if the new tries value equals MAX_TRIES, and go to FILL otherwise.
REQ-023 sol_valid SHALL equal (state==HOLD); sol_data SHALL remain stable while sol_valid=1 and sol_ready=0.
REQ-024 HOLD with sol_ready=1 SHALL go to IDLE on the same edge; sol_ready outside HOLD SHALL be ignored.
REQ-025 start outside IDLE/FAIL SHALL be ignored, with no effect on the LFSR or tries.
REQ-026 FAIL SHALL hold fail=1 and tries=MAX_TRIES until an accepted start.
REQ-027 Minimum latency from an accepted start edge to sol_valid=1 SHALL be NWORDS+1 cycles.

Reset
REQ-028 rst=1 SHALL set state=IDLE, LFSR=SEED, the candidate register, sol_data, and tries to 0, and sol_valid, busy, and fail to 0.
REQ-029 Reset mid-operation SHALL discard any in-flight candidate or held solution without emitting it.

Configuration
REQ-030 With SAMPLE_GENERATOR_STATS_EN defined, the block SHALL add an output stat_acc[31:0] (accepted solutions, incremented on each sol_valid&sol_ready) and an output stat_rej[31:0] (total rejections); both SHALL saturate at 32'hFFFF_FFFF and reset to 0.
REQ-031 Without SAMPLE_GENERATOR_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-032 CAND_W=64, chk_ok tied 1, seed=0, start pulse -> sol_valid rises 3 cycles after the start edge, tries=0, sol_data = first two LFSR words from SEED.
REQ-033 chk_ok=0 for the first 5 CHECKs then 1 -> sol_valid asserted with tries=5, fail=0.
REQ-034 MAX_TRIES=4, chk_ok tied 0 -> fail=1 and tries=4 after 4 CHECKs; a new start clears fail, and the next state is FILL.
REQ-035 sol_ready held 0 for 10 cycles in HOLD, then 1 -> sol_data unchanged for all 10 cycles, IDLE next cycle; a start pulsed during HOLD is ignored.
REQ-036 seed=32'h1234_5678 on two separate requests, chk_ok tied 1 -> identical sol_data both times; rst asserted during FILL -> IDLE immediately, sol_valid never asserted.
REQ-037 With SAMPLE_GENERATOR_STATS_EN: 3 accepted solutions with 2 rejections each -> stat_acc=3, stat_rej=6.
